// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and round helper functions.
package sha1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUNDS,
        UPDATE,
        DONE
    } state_t;

    localparam logic [159:0] IV =
        160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    // Element 0 is the constant for rounds 0-19
    localparam logic [3:0][31:0] K = {
        32'hCA62C1D6, 32'h8F1BBCDC, 32'h6ED9EBA1, 32'h5A827999
    };

    localparam logic [6:0] LAST_ROUND = 7'd79;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] parity(input logic [31:0] b, input logic [31:0] c,
                                           input logic [31:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
        return (b & c) | (b & d) | (c & d);
    endfunction

    function automatic logic [1:0] round_group(input logic [6:0] t);
        if (t < 7'd20) return 2'd0;
        else if (t < 7'd40) return 2'd1;
        else if (t < 7'd60) return 2'd2;
        else return 2'd3;
    endfunction

    function automatic logic [31:0] round_f(input logic [6:0] t, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        case (round_group(t))
            2'd0:    return ch(b, c, d);
            2'd2:    return maj(b, c, d);
            default: return parity(b, c, d);
        endcase
    endfunction

    function automatic logic [31:0] k_of(input logic [6:0] t);
        return K[round_group(t)];
    endfunction

endpackage

// File: rtl/sha1_msg_sched.sv
// SHA-1 message schedule: 16-word shift buffer that yields W_t one word per round.
module sha1_msg_sched
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  w_t
);

    logic [31:0] w [16];

    // w[j] holds W[t+j], so the expansion taps W[t+13], W[t+8], W[t+2], W[t]
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= block[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int i = 0; i < 15; i++) begin
                w[i] <= w[i+1];
            end
            w[15] <= rotl(w[13] ^ w[8] ^ w[2] ^ w[0], 1);
        end
    end

    assign w_t = w[0];

endmodule

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression core: one round per clock, chained H state, held digest.
module sha1_core
    import sha1_pkg::*;
#(
    parameter int unsigned RoundsPerCycle = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [511:0] block_i,
    input  logic         blockvalid_i,
    input  logic         blockinit_i,
    output logic         blockready_o,
    output logic         busy_o,
    output logic [159:0] digest_o,
    output logic         digestvalid_o,
    input  logic         digestack_i
);

    if (RoundsPerCycle != 1) begin : g_bad_rounds
        $error("sha1_core: only RoundsPerCycle == 1 is supported");
    end

    state_t      state;
    logic [6:0]  t;
    logic [31:0] a, b, c, d, e;
    logic [31:0] h [5];
    logic [31:0] w_t;
    logic [31:0] tmp;
    logic        accept;
    logic        shift;

    assign accept = (state == IDLE) && blockvalid_i;
    assign shift  = (state == ROUNDS);

    sha1_msg_sched u_sched (
        .clk   (clk_i),
        .load  (accept),
        .shift (shift),
        .block (block_i),
        .w_t   (w_t)
    );

    assign tmp = rotl(a, 5) + round_f(t, b, c, d) + e + k_of(t) + w_t;

    assign digest_o = {h[0], h[1], h[2], h[3], h[4]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            t             <= '0;
            a             <= '0;
            b             <= '0;
            c             <= '0;
            d             <= '0;
            e             <= '0;
            for (int i = 0; i < 5; i++) begin
                h[i] <= IV[159 - 32*i -: 32];
            end
            blockready_o  <= 1'b1;
            busy_o        <= 1'b0;
            digestvalid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (blockvalid_i) begin
                        // A new message restarts both the working regs and the chain from IV
                        if (blockinit_i) begin
                            a <= IV[159:128];
                            b <= IV[127:96];
                            c <= IV[95:64];
                            d <= IV[63:32];
                            e <= IV[31:0];
                            for (int i = 0; i < 5; i++) begin
                                h[i] <= IV[159 - 32*i -: 32];
                            end
                        end else begin
                            a <= h[0];
                            b <= h[1];
                            c <= h[2];
                            d <= h[3];
                            e <= h[4];
                        end
                        t            <= '0;
                        state        <= ROUNDS;
                        blockready_o <= 1'b0;
                        busy_o       <= 1'b1;
                    end
                end
                ROUNDS: begin
                    a <= tmp;
                    b <= a;
                    c <= rotl(b, 30);
                    d <= c;
                    e <= d;
                    t <= t + 7'd1;
                    if (t == LAST_ROUND) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    h[0]          <= h[0] + a;
                    h[1]          <= h[1] + b;
                    h[2]          <= h[2] + c;
                    h[3]          <= h[3] + d;
                    h[4]          <= h[4] + e;
                    state         <= DONE;
                    busy_o        <= 1'b0;
                    digestvalid_o <= 1'b1;
                end
                DONE: begin
                    if (digestack_i) begin
                        state         <= IDLE;
                        digestvalid_o <= 1'b0;
                        blockready_o  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    blockready_o  <= 1'b1;
                    busy_o        <= 1'b0;
                    digestvalid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_core.sv
// Directed-vector bench for sha1_core using published SHA-1 test digests.
module tb_sha1_core;

    localparam logic [159:0] IV_EXP    = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] ABC_DIG   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] TWO_DIG   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_BLK1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] block;
    logic         blockvalid;
    logic         blockinit;
    logic         blockready;
    logic         busy;
    logic [159:0] digest;
    logic         digestvalid;
    logic         digestack;

    int checks = 0;
    int errors = 0;

    sha1_core #(.RoundsPerCycle(1)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .block_i       (block),
        .blockvalid_i  (blockvalid),
        .blockinit_i   (blockinit),
        .blockready_o  (blockready),
        .busy_o        (busy),
        .digest_o      (digest),
        .digestvalid_o (digestvalid),
        .digestack_i   (digestack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one block for a single edge; caller guarantees the core is in IDLE
    task automatic send_block(input logic [511:0] blk, input logic init);
        @(negedge clk);
        block      = blk;
        blockinit  = init;
        blockvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        blockvalid = 1'b0;
        blockinit  = 1'b0;
    endtask

    // Counts edges (starting from 'start') until digestvalid is seen, bounded
    task automatic wait_digest(input int start, output int edges);
        edges = start;
        while (digestvalid !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        digestack = 1'b1;
        @(negedge clk);
        digestack = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (blockready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_blockready: got %b expected 1", blockready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (digestvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_digestvalid: got %b expected 0", digestvalid);
        end
        checks++;
        if (digest !== IV_EXP) begin
            errors++;
            $display("[TB] FAIL reset_digest: got %h expected %h", digest, IV_EXP);
        end
    endtask

    task automatic test_empty();
        int lat;
        send_block(EMPTY_BLK, 1'b1);
        checks++;
        if (busy !== 1'b1 || blockready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_busy_after_accept: got busy=%b ready=%b expected busy=1 ready=0",
                     busy, blockready);
        end
        wait_digest(0, lat);
        checks++;
        if (lat != 81) begin
            errors++;
            $display("[TB] FAIL empty_latency: got %0d expected 81", lat);
        end
        checks++;
        if (digest !== EMPTY_DIG) begin
            errors++;
            $display("[TB] FAIL empty_digest: got %h expected %h", digest, EMPTY_DIG);
        end
        checks++;
        if (busy !== 1'b0 || blockready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_done_flags: got busy=%b ready=%b expected busy=0 ready=0",
                     busy, blockready);
        end
        do_ack();
        checks++;
        if (digestvalid !== 1'b0 || blockready !== 1'b1 || digest !== EMPTY_DIG) begin
            errors++;
            $display("[TB] FAIL empty_after_ack: got dv=%b ready=%b dig=%h expected dv=0 ready=1 dig=%h",
                     digestvalid, blockready, digest, EMPTY_DIG);
        end
    endtask

    task automatic test_abc();
        int lat;
        send_block(ABC_BLK, 1'b1);
        wait_digest(0, lat);
        checks++;
        if (lat != 81) begin
            errors++;
            $display("[TB] FAIL abc_latency: got %0d expected 81", lat);
        end
        checks++;
        if (digest !== ABC_DIG) begin
            errors++;
            $display("[TB] FAIL abc_digest: got %h expected %h", digest, ABC_DIG);
        end
        do_ack();
    endtask

    task automatic test_two_block();
        int lat;
        send_block(TWO_BLK1, 1'b1);
        wait_digest(0, lat);
        do_ack();
        send_block(TWO_BLK2, 1'b0);
        wait_digest(0, lat);
        checks++;
        if (digest !== TWO_DIG) begin
            errors++;
            $display("[TB] FAIL two_block_digest: got %h expected %h", digest, TWO_DIG);
        end
        do_ack();
    endtask

    task automatic test_backpressure();
        int lat;
        send_block(ABC_BLK, 1'b1);
        wait_digest(0, lat);
        block = EMPTY_BLK;
        for (int i = 0; i < 20; i++) begin
            blockvalid = i[0];
            blockinit  = 1'b1;
            @(negedge clk);
            checks++;
            if (digest !== ABC_DIG || blockready !== 1'b0 || digestvalid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure_hold[%0d]: got dig=%h ready=%b dv=%b busy=%b expected dig=%h ready=0 dv=1 busy=0",
                         i, digest, blockready, digestvalid, busy, ABC_DIG);
            end
        end
        // Keep the request up through the ack edge; it must be taken on the edge after
        blockvalid = 1'b1;
        blockinit  = 1'b1;
        digestack  = 1'b1;
        @(negedge clk);
        digestack  = 1'b0;
        checks++;
        if (blockready !== 1'b1 || busy !== 1'b0 || digestvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_ack_edge: got ready=%b busy=%b dv=%b expected ready=1 busy=0 dv=0",
                     blockready, busy, digestvalid);
        end
        @(negedge clk);
        blockvalid = 1'b0;
        blockinit  = 1'b0;
        checks++;
        if (busy !== 1'b1 || blockready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_next_accept: got busy=%b ready=%b expected busy=1 ready=0",
                     busy, blockready);
        end
        wait_digest(0, lat);
        checks++;
        if (lat != 81 || digest !== EMPTY_DIG) begin
            errors++;
            $display("[TB] FAIL backpressure_next_digest: got lat=%0d dig=%h expected lat=81 dig=%h",
                     lat, digest, EMPTY_DIG);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        send_block(ABC_BLK, 1'b1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (blockready !== 1'b1 || busy !== 1'b0 || digestvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got ready=%b busy=%b dv=%b expected ready=1 busy=0 dv=0",
                     blockready, busy, digestvalid);
        end
        checks++;
        if (digest !== IV_EXP) begin
            errors++;
            $display("[TB] FAIL midreset_digest: got %h expected %h", digest, IV_EXP);
        end
        send_block(ABC_BLK, 1'b1);
        wait_digest(0, lat);
        checks++;
        if (lat != 81 || digest !== ABC_DIG) begin
            errors++;
            $display("[TB] FAIL midreset_abc: got lat=%0d dig=%h expected lat=81 dig=%h",
                     lat, digest, ABC_DIG);
        end
        do_ack();
    endtask

    task automatic test_spurious();
        int lat;
        send_block(TWO_BLK1, 1'b1);
        wait_digest(0, lat);
        do_ack();
        send_block(TWO_BLK2, 1'b0);
        wait_digest(0, lat);
        checks++;
        if (digest !== TWO_DIG) begin
            errors++;
            $display("[TB] FAIL spurious_two_block: got %h expected %h", digest, TWO_DIG);
        end
        do_ack();
        for (int i = 0; i < 3; i++) begin
            do_ack();
            checks++;
            if (blockready !== 1'b1 || busy !== 1'b0 || digestvalid !== 1'b0 || digest !== TWO_DIG) begin
                errors++;
                $display("[TB] FAIL spurious_idle[%0d]: got ready=%b busy=%b dv=%b dig=%h expected ready=1 busy=0 dv=0 dig=%h",
                         i, blockready, busy, digestvalid, digest, TWO_DIG);
            end
        end
        send_block(ABC_BLK, 1'b1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            digestack = i[0];
            @(negedge clk);
            lat++;
            checks++;
            if (busy !== 1'b1 || digestvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL spurious_rounds[%0d]: got busy=%b dv=%b expected busy=1 dv=0",
                         i, busy, digestvalid);
            end
        end
        digestack = 1'b0;
        wait_digest(lat, lat);
        checks++;
        if (lat != 81 || digest !== ABC_DIG) begin
            errors++;
            $display("[TB] FAIL spurious_third_block: got lat=%0d dig=%h expected lat=81 dig=%h",
                     lat, digest, ABC_DIG);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (digestvalid !== 1'b1 || digest !== ABC_DIG) begin
            errors++;
            $display("[TB] FAIL spurious_done_held: got dv=%b dig=%h expected dv=1 dig=%h",
                     digestvalid, digest, ABC_DIG);
        end
        do_ack();
    endtask

    initial begin
        rst_n      = 1'b0;
        block      = '0;
        blockvalid = 1'b0;
        blockinit  = 1'b0;
        digestack  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] starting sha1_core directed tests");
        test_reset();
        test_empty();
        test_abc();
        test_two_block();
        test_backpressure();
        test_reset_mid();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_core.md
Name: sha1_core

Overview:
Iterative SHA-1 compression engine and sequencer. It sits behind the SHA-1 register-interface block: it consumes one 512-bit message block per handshake and runs the 80 rounds at one round per cycle. It chains intermediate hash state across blocks and presents a 160-bit digest that is held until acknowledged. Padding is done by software; this block only compresses.

Parameters:
- RoundsPerCycle, 1, rounds evaluated per clock; only 1 is supported; elaboration fails on any other value.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- block_i  in  512  message block; W[0]=block_i[511:480] ... W[15]=block_i[31:0], big-endian words per FIPS 180-4
- blockvalid_i  in  1  block_i valid
- blockinit_i  in  1  sampled at accept; 1 = first block of a message (chain from IV)
- blockready_o  out  1  core can accept a block
- busy_o  out  1  compression in progress
- digest_o  out  160  H0 in [159:128] ... H4 in [31:0]
- digestvalid_o  out  1  digest_o valid
- digestack_i  in  1  digest consumed

Behaviour:
- All state updates on posedge clk_i. rst_ni=0 at an edge forces the following, regardless of current state, including mid-round:
  - FSM to IDLE, round counter t=0, working regs a..e=0.
  - H regs to IV 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0.
  - Outputs after reset: blockready_o=1, busy_o=0, digestvalid_o=0, digest_o=IV.
- FSM states: IDLE, ROUNDS, UPDATE, DONE.
- IDLE:
  - blockready_o=1.
  - On blockvalid_i=1: latch block_i into the 16-word schedule buffer.
  - Load a..e from IV if blockinit_i=1, else from the current H regs. If blockinit_i=1, also load H regs from IV in the same edge.
  - Set t=0 and go to ROUNDS.
- ROUNDS:
  - busy_o=1. Each edge computes round t and increments t.
  - When t==79 at an edge, go to UPDATE.
  - Round t uses W_t:
    - W_t = buffer word for t<16.
    - For t>=16: W_t = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
    - The buffer is a 16-word shift register that shifts one word per round.
  - f/K by t:
    - 0-19: Ch, 5A827999
    - 20-39: Parity, 6ED9EBA1
    - 40-59: Maj, 8F1BBCDC
    - 60-79: Parity, CA62C1D6
  - Round update: tmp = rotl5(a)+f(b,c,d)+e+K+W_t, all modulo 2^32. Then e<=d, d<=c, c<=rotl30(b), b<=a, a<=tmp.
- UPDATE: busy_o=1. Hi <= Hi + working reg (mod 2^32). Next state DONE.
- DONE:
  - digestvalid_o=1; digest_o=H regs, stable.
  - digestack_i=1 → IDLE at that edge.
- Latency: digestvalid_o rises exactly 81 edges after the accepting edge. Next block can be accepted the edge after the ack edge, so block-to-block period ≥83 cycles.
- digest_o always reflects the H regs, so it is also stable in IDLE after an ack. H persists for chaining when the next block has blockinit_i=0.
- blockvalid_i outside IDLE: ignored, no buffering; the requester must hold it until blockready_o=1.
- digestack_i outside DONE: ignored, with no effect on a later DONE.
- blockready_o=0 and busy_o per state: ROUNDS, UPDATE and DONE all give blockready_o=0; busy_o=1 in ROUNDS and UPDATE only.

Decomposition:
- Package sha1_pkg:
  - IV constant (160-bit).
  - K constants array[4] of 32-bit.
  - FSM state enum.
  - Functions rotl, ch, parity, maj, and round_f(t).
- Sub-module sha1_msg_sched:
  - 16x32 shift buffer with load, shift enable and W_t output.
  - Keeps expansion logic out of the FSM.

Test Plan:
- Empty message: block 80000000 followed by 15 zero words, blockinit_i=1 → digest da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709, digestvalid_o rises 81 edges after accept.
- "abc": words 61626380, 13 zeros, then 00000000, 00000018; blockinit_i=1 → a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits): block 1 with blockinit_i=1, ack, block 2 with blockinit_i=0 → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- Backpressure: hold digestack_i=0 for 20 cycles in DONE while toggling blockvalid_i → digest_o stable, blockready_o=0, no new block accepted. After ack, next block is accepted the following cycle.
- Reset mid-operation: assert rst_ni=0 for one edge at t=40 → next cycle IDLE, digest_o=IV, digestvalid_o=0. A following "abc" run still gives the correct digest.
- Spurious digestack_i pulses in IDLE/ROUNDS, and blockinit_i=1 on a third block after a two-block message → no state change from the pulses; the third block's digest is computed from IV.
